operand_fetch: RTL and testbench

Initiator-side companion to `registerfile`, sitting between decode and execute in the MIPS datapath. It accepts a two-operand read request (rs, rt) and drives the register file's read-address ports. It absorbs the file's one-cycle registered read latency and forwards any writeback landing while the read is in flight. It then presents coherent operand values through a valid/ready handshake, and passes writeback traffic through to the file's write port.

---
 rtl/mips_rf_pkg.sv | 11 +
 rtl/operand_fetch_if.sv | 27 ++
 rtl/operand_fwd_mux.sv | 17 +
 rtl/operand_fetch.sv | 81 ++++++++
 tb/tb_operand_fetch.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mips_rf_pkg.sv
// mips_rf_pkg: widths, operand-fetch FSM states and register index names
// shared by the register file and its operand-fetch front end.
package mips_rf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, VALID} of_state_t;
  localparam logic [ADDR_W-1:0] S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3;
  localparam logic [ADDR_W-1:0] S4 = 4'd4, S5 = 4'd5, S6 = 4'd6, S7 = 4'd7;
  localparam logic [ADDR_W-1:0] T0 = 4'd8, T1 = 4'd9, T2 = 4'd10, T3 = 4'd11;
  localparam logic [ADDR_W-1:0] T4 = 4'd12, T5 = 4'd13, T6 = 4'd14, T7 = 4'd15;
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode-side bus of operand_fetch.
//   req_*  : operand request (valid/ready, rs/rt indices)
//   wb_*   : writeback strobe, register and value (always accepted)
//   op_*   : operand response (valid/ready, a/b values)
// master = decode/execute side, slave = operand_fetch.
interface operand_fetch_if;
  import mips_rf_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [ADDR_W-1:0] req_rs;
  logic [ADDR_W-1:0] req_rt;
  logic wb_valid;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic op_valid;
  logic op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  modport master (
    output req_valid, req_rs, req_rt, wb_valid, wb_reg, wb_data, op_ready,
    input req_ready, op_valid, op_a, op_b
  );
  modport slave (
    input req_valid, req_rs, req_rt, wb_valid, wb_reg, wb_data, op_ready,
    output req_ready, op_valid, op_a, op_b
  );
endinterface

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: per-operand source select, newest value wins.
//   wb_hit/wb_data     : writeback landing this cycle on the operand's register
//   fwd/fwd_data       : writeback captured while the file read was in flight
//   rf_data            : registered read data from the file
//   data               : selected operand value
module operand_fwd_mux
  import mips_rf_pkg::*;
(
  input  logic              wb_hit,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              fwd,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] data
);
  assign data = wb_hit ? wb_data : fwd ? fwd_data : rf_data;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: drives the register file read ports for an (rs, rt) request,
// hides its one-cycle read latency, forwards in-flight writebacks and returns
// coherent operands over a valid/ready handshake.
//   clk, rst          : clock, asynchronous active-low reset
//   bus               : request / writeback / operand bus (slave side)
//   rf_dataIn, rf_dataInRegister, rf_enableSavingDataIn : file write port
//   rf_dataOutRegisterA/B : file read addresses
//   rf_registerA/B        : registered file read data
module operand_fetch
  import mips_rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  operand_fetch_if.slave    bus,
  output logic [DATA_W-1:0] rf_dataIn,
  output logic [ADDR_W-1:0] rf_dataInRegister,
  output logic              rf_enableSavingDataIn,
  output logic [ADDR_W-1:0] rf_dataOutRegisterA,
  output logic [ADDR_W-1:0] rf_dataOutRegisterB,
  input  logic [DATA_W-1:0] rf_registerA,
  input  logic [DATA_W-1:0] rf_registerB
);
  of_state_t state, state_nx;
  logic [ADDR_W-1:0] rs_q, rt_q;
  logic fwd_a, fwd_b, hit_a, hit_b;
  logic [DATA_W-1:0] fwd_data, op_a, op_b, mux_a, mux_b;
  assign rf_enableSavingDataIn = bus.wb_valid;
  assign rf_dataInRegister = bus.wb_reg;
  assign rf_dataIn = bus.wb_data;
  assign rf_dataOutRegisterA = rs_q;
  assign rf_dataOutRegisterB = rt_q;
  assign hit_a = bus.wb_valid && bus.wb_reg == rs_q;
  assign hit_b = bus.wb_valid && bus.wb_reg == rt_q;
  assign bus.req_ready = state == IDLE;
  assign bus.op_valid = state == VALID;
  assign bus.op_a = op_a;
  assign bus.op_b = op_b;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (bus.req_valid ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? VALID :
               (bus.op_ready ? IDLE : VALID);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  operand_fwd_mux mux_a_i (.wb_hit(hit_a), .wb_data(bus.wb_data), .fwd(fwd_a),
                           .fwd_data(fwd_data), .rf_data(rf_registerA), .data(mux_a));
  operand_fwd_mux mux_b_i (.wb_hit(hit_b), .wb_data(bus.wb_data), .fwd(fwd_b),
                           .fwd_data(fwd_data), .rf_data(rf_registerB), .data(mux_b));
  // The file samples rs_q/rt_q at the end of ISSUE and returns the pre-write
  // value, so a writeback landing in that same cycle is captured here. Both
  // flags share one capture register since both hits carry the same wb_data.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rs_q <= '0;
      rt_q <= '0;
      fwd_a <= 1'b0;
      fwd_b <= 1'b0;
      fwd_data <= '0;
      op_a <= '0;
      op_b <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        rs_q <= bus.req_rs;
        rt_q <= bus.req_rt;
      end
      if (state == ISSUE) begin
        fwd_a <= hit_a;
        fwd_b <= hit_b;
        fwd_data <= bus.wb_data;
      end
      if (state == WAIT) begin
        op_a <= mux_a;
        op_b <= mux_b;
      end
      if (state == VALID && hit_a) op_a <= bus.wb_data;
      if (state == VALID && hit_b) op_b <= bus.wb_data;
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed stimulus for operand_fetch against a behavioural
// register file with a one-cycle registered read; expected operands go into a
// scoreboard queue and a monitor checks every op handshake.
module tb_operand_fetch;
  import mips_rf_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [DATA_W-1:0] rf_dataIn, rf_registerA, rf_registerB;
  logic [ADDR_W-1:0] rf_dataInRegister, rf_dataOutRegisterA, rf_dataOutRegisterB;
  logic rf_enableSavingDataIn;
  logic [DATA_W-1:0] regs [16];
  logic [2*DATA_W-1:0] sb [$];
  int checks = 0;
  int errors = 0;
  int accepts;
  operand_fetch_if bus ();
  operand_fetch dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rf_dataIn(rf_dataIn), .rf_dataInRegister(rf_dataInRegister),
    .rf_enableSavingDataIn(rf_enableSavingDataIn),
    .rf_dataOutRegisterA(rf_dataOutRegisterA), .rf_dataOutRegisterB(rf_dataOutRegisterB),
    .rf_registerA(rf_registerA), .rf_registerB(rf_registerB)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      rf_registerA <= '0;
      rf_registerB <= '0;
    end else begin
      if (rf_enableSavingDataIn) regs[rf_dataInRegister] <= rf_dataIn;
      rf_registerA <= regs[rf_dataOutRegisterA];
      rf_registerB <= regs[rf_dataOutRegisterB];
    end
  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wb(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_reg = r;
    bus.wb_data = d;
    #1;
    check("wb_en", {31'd0, rf_enableSavingDataIn}, 32'd1);
    check("wb_reg", {28'd0, rf_dataInRegister}, {28'd0, r});
    check("wb_data", rf_dataIn, d);
    step();
    bus.wb_valid = 1'b0;
  endtask
  task automatic req(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt);
    bus.req_valid = 1'b1;
    bus.req_rs = rs;
    bus.req_rt = rt;
    step();
    bus.req_valid = 1'b0;
    check("req_ready_issue", {31'd0, bus.req_ready}, 32'd0);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (bus.op_valid && bus.op_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got a=%h b=%h expected no operands", bus.op_a, bus.op_b);
        end else begin
          logic [2*DATA_W-1:0] e;
          e = sb.pop_front();
          check("op_a", bus.op_a, e[2*DATA_W-1:DATA_W]);
          check("op_b", bus.op_b, e[DATA_W-1:0]);
        end
      end
    end
  end
  initial begin
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rs = '0;
    bus.req_rt = '0;
    bus.wb_valid = 1'b0;
    bus.wb_reg = '0;
    bus.wb_data = '0;
    bus.op_ready = 1'b1;
    repeat (2) step();
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
    check("rst_op_a", bus.op_a, 32'd0);
    check("rst_op_b", bus.op_b, 32'd0);
    check("rst_rd_addr", {24'd0, rf_dataOutRegisterA, rf_dataOutRegisterB}, 32'd0);
    rst = 1'b1;
    step();
    // no hazard
    wb(S3, 32'h11);
    wb(T2, 32'h22);
    sb.push_back({32'h11, 32'h22});
    req(S3, T2);
    step();
    check("lat_wait", {31'd0, bus.op_valid}, 32'd0);
    step();
    check("lat_valid", {31'd0, bus.op_valid}, 32'd1);
    step();
    check("idle_ready", {31'd0, bus.req_ready}, 32'd1);
    // ISSUE-cycle forward, rs == rt
    wb(S1, 32'h5);
    sb.push_back({32'h99, 32'h99});
    req(S1, S1);
    wb(S1, 32'h99);
    step();
    step();
    // WAIT-cycle wb overrides ISSUE capture
    sb.push_back({32'hB, 32'h11});
    req(T0, S3);
    wb(T0, 32'hA);
    wb(T0, 32'hB);
    step();
    step();
    // VALID stall with writeback tracking, stray request ignored
    bus.op_ready = 1'b0;
    sb.push_back({32'h11, 32'h77});
    req(S3, S7);
    step();
    step();
    check("stall_valid0", {31'd0, bus.op_valid}, 32'd1);
    check("stall_b_old", bus.op_b, 32'd0);
    bus.req_valid = 1'b1;
    bus.req_rs = S5;
    bus.req_rt = S6;
    wb(S7, 32'h77);
    check("stall_b_new", bus.op_b, 32'h77);
    check("stall_ready1", {31'd0, bus.req_ready}, 32'd0);
    step();
    check("stall_valid2", {31'd0, bus.op_valid}, 32'd1);
    check("stall_ready2", {31'd0, bus.req_ready}, 32'd0);
    check("stall_addr", {28'd0, rf_dataOutRegisterA}, {28'd0, S3});
    bus.req_valid = 1'b0;
    bus.op_ready = 1'b1;
    step();
    step();
    // reset in WAIT discards the request
    req(S3, T2);
    step();
    rst = 1'b0;
    #1;
    check("rstw_op_valid", {31'd0, bus.op_valid}, 32'd0);
    check("rstw_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rstw_op_a", bus.op_a, 32'd0);
    step();
    rst = 1'b1;
    step();
    wb(S2, 32'h42);
    sb.push_back({32'h42, 32'h42});
    req(S2, S2);
    step();
    step();
    step();
    // back-to-back: one accept per 4 cycles
    repeat (3) sb.push_back({32'h42, 32'h0});
    accepts = 0;
    bus.req_valid = 1'b1;
    bus.req_rs = S2;
    bus.req_rt = S0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.req_ready) accepts++;
      step();
    end
    bus.req_valid = 1'b0;
    check("b2b_accepts", accepts, 32'd3);
    repeat (3) step();
    check("sb_drain", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
